// File: rtl/nib_seq_cmp_pkg.sv
// rtl/nib_seq_cmp_pkg.sv - shared state encodings, nibble width and index sizing helper
package nib_seq_cmp_pkg;

  localparam int NIB_W = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // A single-nibble compare still needs a one-bit index register.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/nib_seq_cmp_if.sv
// rtl/nib_seq_cmp_if.sv - start/busy/done handshake and operand bundle for nib_seq_cmp
interface nib_seq_cmp_if #(parameter int WIDTH = 16) ();

  logic             start_i;
  logic [WIDTH-1:0] A_i;
  logic [WIDTH-1:0] B_i;
  logic             busy_o;
  logic             done_o;
  logic             eq_o;

  modport master (
    output start_i, A_i, B_i,
    input  busy_o, done_o, eq_o
  );

  modport slave (
    input  start_i, A_i, B_i,
    output busy_o, done_o, eq_o
  );

endinterface

// File: rtl/nib_seq_cmp_eq.sv
// rtl/nib_seq_cmp_eq.sv - combinational 4-bit equality shared by every nibble step
module nib_eq_cmp
  import nib_seq_cmp_pkg::*;
(
  input  logic [NIB_W-1:0] a_i4,
  input  logic [NIB_W-1:0] b_i4,
  output logic             eq_o
);

  assign eq_o = (a_i4 == b_i4);

endmodule

// File: rtl/nib_seq_cmp.sv
// rtl/nib_seq_cmp.sv - sequential wide-word equality, one nibble per clock, LSB nibble first
// Optional build macro NIB_CMP_EARLY_EXIT_EN: finish on the first mismatching nibble.
module nib_seq_cmp
  import nib_seq_cmp_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic       clk_i,
  input  logic       rst_i,
  nib_seq_cmp_if.slave bus
);

  localparam int N     = WIDTH / NIB_W;
  localparam int IDX_W = idx_width(N);

  generate
    if ((WIDTH % NIB_W) != 0 || WIDTH < NIB_W) begin : g_bad_width
      $error("nib_seq_cmp: WIDTH must be a multiple of 4 and at least 4");
    end
  endgenerate

  state_t           state, state_n;
  logic [IDX_W-1:0] idx, idx_n;
  logic             acc, acc_n;
  logic             load, last, early_stop, nib_eq;
  logic [WIDTH-1:0] a_r, b_r;
  logic [NIB_W-1:0] a_nib, b_nib;
  logic             busy, done, eq;

  always_comb begin
    a_nib = '0;
    b_nib = '0;
    for (int j = 0; j < N; j++) begin
      if (idx == IDX_W'(j)) begin
        a_nib = a_r[NIB_W*j +: NIB_W];
        b_nib = b_r[NIB_W*j +: NIB_W];
      end
    end
  end

  nib_eq_cmp u_nib_eq (
    .a_i4 (a_nib),
    .b_i4 (b_nib),
    .eq_o (nib_eq)
  );

  assign last = (idx == IDX_W'(N - 1));

`ifdef NIB_CMP_EARLY_EXIT_EN
  assign early_stop = !nib_eq;
`else
  assign early_stop = 1'b0;
`endif

  always_comb begin
    state_n = state;
    idx_n   = idx;
    acc_n   = acc;
    load    = 1'b0;
    case (state)
      ST_IDLE: begin
        if (bus.start_i) begin
          load    = 1'b1;
          idx_n   = '0;
          acc_n   = 1'b1;
          state_n = ST_RUN;
        end
      end
      ST_RUN: begin
        acc_n = acc & nib_eq;
        // idx holds at the last nibble so it never wraps.
        if (last || early_stop) state_n = ST_DONE;
        else                    idx_n   = idx + 1'b1;
      end
      ST_DONE: state_n = ST_IDLE;
      default: state_n = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state <= ST_IDLE;
      idx   <= '0;
      acc   <= 1'b1;
      a_r   <= '0;
      b_r   <= '0;
      busy  <= 1'b0;
      done  <= 1'b0;
      eq    <= 1'b0;
    end else begin
      state <= state_n;
      idx   <= idx_n;
      acc   <= acc_n;
      if (load) begin
        a_r <= bus.A_i;
        b_r <= bus.B_i;
      end
      busy <= (state_n != ST_IDLE);
      done <= (state_n == ST_DONE);
      // Result only moves on DONE entry and holds through IDLE.
      if (state_n == ST_DONE) eq <= acc_n;
    end
  end

  assign bus.busy_o = busy;
  assign bus.done_o = done;
  assign bus.eq_o   = eq;

endmodule
